// File: rtl/io_bus_pkg.sv
// Shared defaults for the CPU I/O bus hub: bus width, device-code map and a window-overlap helper.
package io_bus_pkg;

  localparam int unsigned BUS_DATA_W = 16;

  localparam logic [15:0] DEF_OUT_BASE  = 16'h0020;
  localparam logic [15:0] DEF_IN_BASE   = 16'h0050;
  localparam logic [15:0] DEF_MASK_ADDR = 16'h00F0;
  localparam logic [15:0] DEF_IDLE_CODE = 16'h0000;

  // True when the half-open code windows [a, a+na) and [b, b+nb) intersect.
  function automatic bit ranges_overlap(input int unsigned a, input int unsigned na,
                                        input int unsigned b, input int unsigned nb);
    return (a < b + nb) && (b < a + na);
  endfunction

endpackage

// File: rtl/io_in_channel.sv
// One peripheral input channel: holding register, pending flag and sticky overrun.
module io_in_channel #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              read,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] hold,
  output logic              pending,
  output logic              overrun
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        hold <= cap_data;
      end

      if (capture) begin
        pending <= 1'b1;
      end else if (read) begin
        pending <= 1'b0;
      end

      // A capture racing a read consumes the old value, so it is not an overrun.
      if (capture && pending && !read) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_bus_hub.sv
// CPU device/data bus hub: registered decode into output registers and interrupting input channels.
// Optional status read at IN_BASE+N_IN is enabled by defining IO_BUS_STATUS_EN.
module io_bus_hub
  import io_bus_pkg::*;
#(
  parameter int unsigned       DATA_W    = BUS_DATA_W,
  parameter int unsigned       N_OUT     = 4,
  parameter int unsigned       OUT_W     = 8,
  parameter logic [DATA_W-1:0] OUT_BASE  = DATA_W'(DEF_OUT_BASE),
  parameter int unsigned       N_IN      = 4,
  parameter logic [DATA_W-1:0] IN_BASE   = DATA_W'(DEF_IN_BASE),
  parameter logic [DATA_W-1:0] MASK_ADDR = DATA_W'(DEF_MASK_ADDR),
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(DEF_IDLE_CODE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       out_device,
  input  logic [DATA_W-1:0]       out_data,
  output logic [DATA_W-1:0]       in_data,
  output logic                    itr,
  output logic [N_OUT*OUT_W-1:0]  out_regs,
  output logic [N_OUT-1:0]        out_wstb,
  input  logic [N_IN*DATA_W-1:0]  in_chan_data,
  input  logic [N_IN-1:0]         in_chan_valid,
  output logic [N_IN-1:0]         in_chan_ack
);

`ifdef IO_BUS_STATUS_EN
  localparam int unsigned InLen = N_IN + 1;
`else
  localparam int unsigned InLen = N_IN;
`endif

  if (N_IN > 16 || N_IN == 0) begin : g_nin_err
    $error("io_bus_hub: N_IN must be in 1..16");
  end
  if (ranges_overlap(32'(OUT_BASE), N_OUT, 32'(IN_BASE), InLen) ||
      ranges_overlap(32'(OUT_BASE), N_OUT, 32'(MASK_ADDR), 1) ||
      ranges_overlap(32'(IN_BASE), InLen, 32'(MASK_ADDR), 1)) begin : g_overlap_err
    $error("io_bus_hub: device-code windows overlap");
  end

  logic [DATA_W-1:0] dev_q, data_q, dev_prev_q;
  logic [N_IN-1:0]   mask_q;
  logic              fire;

  logic [N_OUT-1:0]  out_hit;
  logic [N_IN-1:0]   in_hit;
  logic              mask_hit;
  logic              status_hit;
  logic [DATA_W-1:0] in_sel;

  logic [DATA_W-1:0] hold [N_IN];
  logic [N_IN-1:0]   pending;
  logic [N_IN-1:0]   overrun;

  logic unused_data;
  assign unused_data = ^data_q;

  // Commands execute on the cycle the registered device code changes.
  assign fire = (dev_q != dev_prev_q);

  always_comb begin
    logic [N_OUT-1:0] out_match;
    logic [N_IN-1:0]  in_match;
    out_match  = '0;
    in_match   = '0;
    out_hit    = '0;
    in_hit     = '0;
    mask_hit   = 1'b0;
    status_hit = 1'b0;
    in_sel     = in_data;

    for (int i = 0; i < N_OUT; i++) begin
      out_match[i] = (dev_q == OUT_BASE + DATA_W'(i));
    end
    for (int j = 0; j < N_IN; j++) begin
      in_match[j] = (dev_q == IN_BASE + DATA_W'(j));
    end

    if (fire) begin
      if (out_match != '0) begin
        out_hit = out_match;
      end else if (in_match != '0) begin
        in_hit = in_match;
      end else if (dev_q == MASK_ADDR) begin
        mask_hit = 1'b1;
`ifdef IO_BUS_STATUS_EN
      end else if (dev_q == IN_BASE + DATA_W'(N_IN)) begin
        status_hit = 1'b1;
`endif
      end
    end

    for (int j = 0; j < N_IN; j++) begin
      if (in_hit[j]) begin
        in_sel = hold[j];
      end
    end
    if (status_hit) begin
      in_sel = DATA_W'({overrun, pending});
    end
  end

  for (genvar j = 0; j < N_IN; j++) begin : g_chan
    io_in_channel #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .capture  (in_chan_valid[j]),
      .cap_data (in_chan_data[j*DATA_W +: DATA_W]),
      .read     (in_hit[j]),
      .ovr_clr  (status_hit),
      .hold     (hold[j]),
      .pending  (pending[j]),
      .overrun  (overrun[j])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dev_q       <= '0;
      data_q      <= '0;
      dev_prev_q  <= IDLE_CODE;
      mask_q      <= '0;
      out_regs    <= '0;
      out_wstb    <= '0;
      in_data     <= '0;
      in_chan_ack <= '0;
      itr         <= 1'b0;
    end else begin
      dev_q       <= out_device;
      data_q      <= out_data;
      dev_prev_q  <= dev_q;
      out_wstb    <= out_hit;
      in_chan_ack <= in_hit;
      in_data     <= in_sel;
      itr         <= |(pending & mask_q);
      if (mask_hit) begin
        mask_q <= data_q[N_IN-1:0];
      end
      for (int i = 0; i < N_OUT; i++) begin
        if (out_hit[i]) begin
          out_regs[i*OUT_W +: OUT_W] <= data_q[OUT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_hub.sv
// Directed self-checking bench for io_bus_hub; status checks compile in with IO_BUS_STATUS_EN.
module tb_io_bus_hub;

  logic        clk;
  logic        rst;
  logic [15:0] out_device;
  logic [15:0] out_data;
  logic [15:0] in_data;
  logic        itr;
  logic [31:0] out_regs;
  logic [3:0]  out_wstb;
  logic [63:0] in_chan_data;
  logic [3:0]  in_chan_valid;
  logic [3:0]  in_chan_ack;

  int checks = 0;
  int errors = 0;

  io_bus_hub dut (
    .clk           (clk),
    .rst           (rst),
    .out_device    (out_device),
    .out_data      (out_data),
    .in_data       (in_data),
    .itr           (itr),
    .out_regs      (out_regs),
    .out_wstb      (out_wstb),
    .in_chan_data  (in_chan_data),
    .in_chan_valid (in_chan_valid),
    .in_chan_ack   (in_chan_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and wait until it has taken effect (two edges).
  task automatic cpu_issue(input logic [15:0] dev, input logic [15:0] dat);
    out_device = dev;
    out_data   = dat;
    tick();
    tick();
  endtask

  task automatic cpu_idle();
    out_device = 16'h0000;
    tick();
  endtask

  task automatic capture(input int ch, input logic [15:0] dat);
    in_chan_data[ch*16 +: 16] = dat;
    in_chan_valid[ch]         = 1'b1;
    tick();
    in_chan_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_regs !== 32'h0 || out_wstb !== 4'h0 || in_data !== 16'h0 ||
        itr !== 1'b0 || in_chan_ack !== 4'h0) begin
      errors++;
      $display("FAIL reset: regs=%h wstb=%b in_data=%h itr=%b ack=%b, expected all zero",
               out_regs, out_wstb, in_data, itr, in_chan_ack);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_output_write();
    int pulses = 0;
    out_device = 16'h0021;
    out_data   = 16'h00A5;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (out_wstb[1]) pulses++;
      if (k == 1) begin
        checks++;
        if (out_regs !== 32'h0) begin
          errors++;
          $display("FAIL wr_latency: regs=%h after 1 clk, expected 00000000", out_regs);
        end
      end
      if (k == 2) begin
        checks++;
        if (out_regs !== 32'h0000_A500 || out_wstb !== 4'b0010) begin
          errors++;
          $display("FAIL wr_first: regs=%h wstb=%b, expected 0000a500 0010", out_regs, out_wstb);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL wr_held_once: %0d strobe cycles, expected 1", pulses);
    end
    cpu_idle();
    cpu_issue(16'h0021, 16'h003C);
    checks++;
    if (out_regs !== 32'h0000_3C00 || out_wstb !== 4'b0010) begin
      errors++;
      $display("FAIL wr_rearm: regs=%h wstb=%b, expected 00003c00 0010", out_regs, out_wstb);
    end
    tick();
    checks++;
    if (out_wstb !== 4'b0000) begin
      errors++;
      $display("FAIL wr_pulse_end: wstb=%b, expected 0000", out_wstb);
    end
    // Device changes while data is unchanged: must still fire.
    out_device = 16'h0022;
    tick();
    tick();
    checks++;
    if (out_regs !== 32'h003C_3C00 || out_wstb !== 4'b0100) begin
      errors++;
      $display("FAIL wr_dev_change: regs=%h wstb=%b, expected 003c3c00 0100", out_regs, out_wstb);
    end
    cpu_idle();
  endtask

  task automatic test_capture_read();
    capture(2, 16'h1234);
    cpu_issue(16'h00F0, 16'h0004);
    checks++;
    if (itr !== 1'b0) begin
      errors++;
      $display("FAIL itr_mask_lat: itr=%b on mask-write edge, expected 0", itr);
    end
    cpu_idle();
    checks++;
    if (itr !== 1'b1) begin
      errors++;
      $display("FAIL itr_rise: itr=%b, expected 1", itr);
    end
    cpu_issue(16'h0052, 16'h0000);
    checks++;
    if (in_data !== 16'h1234 || in_chan_ack !== 4'b0100 || itr !== 1'b1) begin
      errors++;
      $display("FAIL read_ch2: in_data=%h ack=%b itr=%b, expected 1234 0100 1",
               in_data, in_chan_ack, itr);
    end
    cpu_idle();
    checks++;
    if (in_chan_ack !== 4'b0000 || itr !== 1'b0 || in_data !== 16'h1234) begin
      errors++;
      $display("FAIL read_ch2_after: in_data=%h ack=%b itr=%b, expected 1234 0000 0",
               in_data, in_chan_ack, itr);
    end
  endtask

  task automatic test_overrun();
    capture(0, 16'h0001);
    capture(0, 16'h0002);
`ifdef IO_BUS_STATUS_EN
    cpu_issue(16'h0054, 16'h0000);
    checks++;
    if (in_data !== 16'h0011) begin
      errors++;
      $display("FAIL status_ovr: in_data=%h, expected 0011", in_data);
    end
    cpu_idle();
`endif
    cpu_issue(16'h0050, 16'h0000);
    checks++;
    if (in_data !== 16'h0002 || in_chan_ack !== 4'b0001) begin
      errors++;
      $display("FAIL ovr_newest: in_data=%h ack=%b, expected 0002 0001", in_data, in_chan_ack);
    end
    cpu_idle();
`ifdef IO_BUS_STATUS_EN
    cpu_issue(16'h0054, 16'h0000);
    checks++;
    if (in_data !== 16'h0000) begin
      errors++;
      $display("FAIL status_clear: in_data=%h, expected 0000", in_data);
    end
    cpu_idle();
`endif
  endtask

  task automatic test_simultaneous();
    capture(3, 16'h1111);
    out_device = 16'h0053;
    tick();
    // Capture lands on the same edge the read fires.
    in_chan_data[3*16 +: 16] = 16'hBEEF;
    in_chan_valid[3]         = 1'b1;
    tick();
    in_chan_valid = '0;
    checks++;
    if (in_data !== 16'h1111 || in_chan_ack !== 4'b1000) begin
      errors++;
      $display("FAIL simul_old: in_data=%h ack=%b, expected 1111 1000", in_data, in_chan_ack);
    end
    cpu_idle();
    cpu_issue(16'h00F0, 16'h0008);
    cpu_idle();
    checks++;
    if (itr !== 1'b1) begin
      errors++;
      $display("FAIL simul_pending: itr=%b, expected 1", itr);
    end
`ifdef IO_BUS_STATUS_EN
    cpu_issue(16'h0054, 16'h0000);
    checks++;
    if (in_data !== 16'h0008) begin
      errors++;
      $display("FAIL simul_no_ovr: status=%h, expected 0008", in_data);
    end
    cpu_idle();
`endif
    cpu_issue(16'h0053, 16'h0000);
    checks++;
    if (in_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL simul_new: in_data=%h, expected beef", in_data);
    end
    cpu_idle();
    checks++;
    if (itr !== 1'b0) begin
      errors++;
      $display("FAIL simul_itr_clear: itr=%b, expected 0", itr);
    end
  endtask

  task automatic test_masked();
    cpu_issue(16'h00F0, 16'h0000);
    cpu_idle();
    capture(1, 16'h00AA);
    tick();
    tick();
    checks++;
    if (itr !== 1'b0) begin
      errors++;
      $display("FAIL masked_itr: itr=%b, expected 0", itr);
    end
    cpu_issue(16'h00F0, 16'h0002);
    cpu_idle();
    checks++;
    if (itr !== 1'b1) begin
      errors++;
      $display("FAIL unmask_itr: itr=%b, expected 1", itr);
    end
    cpu_issue(16'h0051, 16'h0000);
    cpu_idle();
    checks++;
    if (in_data !== 16'h00AA || itr !== 1'b0) begin
      errors++;
      $display("FAIL masked_read: in_data=%h itr=%b, expected 00aa 0", in_data, itr);
    end
  endtask

  task automatic test_unmatched();
    cpu_issue(16'h0060, 16'h00FF);
    checks++;
    if (in_data !== 16'h00AA || out_wstb !== 4'h0 || in_chan_ack !== 4'h0 ||
        out_regs !== 32'h003C_3C00) begin
      errors++;
      $display("FAIL unmatched: in_data=%h wstb=%b ack=%b regs=%h, expected 00aa 0000 0000 003c3c00",
               in_data, out_wstb, in_chan_ack, out_regs);
    end
    cpu_idle();
  endtask

  task automatic test_reset_mid();
    capture(0, 16'h5555);
    out_device = 16'h0020;
    out_data   = 16'h0077;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out_regs !== 32'h0 || out_wstb !== 4'h0 || in_chan_ack !== 4'h0 || in_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: regs=%h wstb=%b ack=%b in_data=%h, expected all zero",
               out_regs, out_wstb, in_chan_ack, in_data);
    end
    out_device = 16'h0000;
    rst        = 1'b0;
    tick();
    cpu_issue(16'h00F0, 16'h000F);
    cpu_idle();
    tick();
    checks++;
    if (itr !== 1'b0 || out_regs !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending: itr=%b regs=%h, expected 0 00000000", itr, out_regs);
    end
  endtask

  initial begin
    rst           = 1'b1;
    out_device    = '0;
    out_data      = '0;
    in_chan_data  = '0;
    in_chan_valid = '0;
    test_reset();
    test_output_write();
    test_capture_read();
    test_overrun();
    test_simultaneous();
    test_masked();
    test_unmatched();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_hub.md
Name: io_bus_hub

Overview:
- Parametrised successor to the CPU DEVICE/DATA I/O decoder. Registers the CPU output bus, decodes device codes into N_OUT write-only output registers, and services N_IN peripheral input channels.
- Each input channel has a holding register, a pending flag, overrun detection and a maskable interrupt line back to the CPU (ITR).
- Commands execute once per device-code change, not every cycle the code is held.
- Sits between CPU_CORE and peripherals (LED banks, keypad, switches, keyboard, distance sensor).

Parameters:
- DATA_W, 16, CPU data/device bus width.
- N_OUT, 4, number of output registers.
- OUT_W, 8, width of each output register (low bits of data taken).
- OUT_BASE, 16'h0020, device code of output register 0; register i at OUT_BASE+i.
- N_IN, 4, number of input channels (max 16).
- IN_BASE, 16'h0050, device code of input channel 0; channel j at IN_BASE+j.
- MASK_ADDR, 16'h00F0, device code writing the interrupt mask (low N_IN bits of data).
- IDLE_CODE, 16'h0000, device code that re-arms command execution.

Ports:
- clk  in  1  system clock (clk_50 domain).
- rst  in  1  synchronous active-high reset.
- out_device  in  DATA_W  CPU device code.
- out_data  in  DATA_W  CPU data.
- in_data  out  DATA_W  data returned to CPU.
- itr  out  1  interrupt to CPU.
- out_regs  out  N_OUT*OUT_W  packed output registers; register i at [i*OUT_W +: OUT_W].
- out_wstb  out  N_OUT  one-cycle pulse when output register i is written.
- in_chan_data  in  N_IN*DATA_W  packed peripheral data.
- in_chan_valid  in  N_IN  one-cycle capture strobe per channel.
- in_chan_ack  out  N_IN  one-cycle pulse when channel j is read by CPU.

Behaviour:
- Reset (rst=1 at posedge clk): all registers clear on that edge. out_regs=0, out_wstb=0, in_data=0, itr=0, in_chan_ack=0, mask=0, holds=0, pending=0, overrun=0, dev_q=0, data_q=0, dev_prev=IDLE_CODE.
- Stage 1: dev_q<=out_device, data_q<=out_data every cycle.
- Command fires in cycle t+1 when dev_q != dev_prev (dev_prev<=dev_q each cycle). Total latency 2 clocks from CPU bus to effect.
- A held code fires once. Re-issuing the same code requires an intervening different code, e.g. IDLE_CODE.
- A dev_q change while data is unchanged still fires.
- Output write (dev_q==OUT_BASE+i): out_regs[i]<=data_q[OUT_W-1:0]; out_wstb[i]=1 for exactly one cycle.
- Mask write (dev_q==MASK_ADDR): mask<=data_q[N_IN-1:0].
- Capture: in_chan_valid[j]=1 means hold[j]<=in_chan_data[j] and pending[j]<=1. If pending[j] was already 1, overrun[j]<=1; newest data wins.
- Read (dev_q==IN_BASE+j fires): in_data<=hold[j]; pending[j]<=0; in_chan_ack[j]=1 for one cycle.
- Read and capture of the same channel in the same cycle: in_data gets the old hold. The new value is latched, pending stays 1, and no overrun is raised.
- Unmatched codes (including IDLE_CODE) have no effect. in_data holds its last value.
- itr<=|(pending & mask), registered, so it follows a pending change by 1 clock.
- Decode windows are checked in priority order OUT, IN, MASK. Overlapping windows are a configuration error; an elaboration-time check flags them.
- Reset asserted mid-command: reset wins, and no strobe or ack is emitted that cycle.

Optional Feature:
- Macro: IO_BUS_STATUS_EN.
- Defined: device code IN_BASE+N_IN is a status read. in_data<={overrun[N_IN-1:0], pending[N_IN-1:0]}, zero-extended, with overrun in the upper bits. The read clears all overrun bits, except bits set by a capture in the same cycle.
- Undefined: that code is unmatched, and overrun is internal only; it sticks until reset.

Decomposition:
- Package io_bus_pkg holds default device-code constants (OUT_BASE, IN_BASE, MASK_ADDR, IDLE_CODE) and a DATA_W localparam.
- Sub-module io_in_channel (one per channel, generate loop) holds hold/pending/overrun, with capture, read and clear inputs.
- Decode, mask, the in_data mux and itr live in io_bus_hub.

Test Plan:
- Output write: device 0x0021, data 0x00A5, held 5 cycles. Expect out_regs[1]=0xA5 two clocks later and out_wstb[1] high exactly 1 cycle. Then 0x0000 followed by 0x0021/0x003C gives a second pulse and value 0x3C.
- Capture/read: in_chan_valid[2] with 0x1234. With mask=0x4 (write to 0x00F0), itr rises 1 clock later. Device 0x0052 gives in_data=0x1234, in_chan_ack[2] pulse, and itr low 1 clock after pending clears.
- Overrun: valid[0] with 0x0001, then 0x0002 with no read. Read 0x0050 returns 0x0002. With IO_BUS_STATUS_EN, status read before the data read gives 0x0011; after both reads status is 0x0000.
- Simultaneous: read fires on channel 3 in the same cycle as valid[3] with 0xBEEF. Expect in_data=old hold, pending[3]=1, overrun[3]=0, and a subsequent read returns 0xBEEF.
- Masked: pending on channel 1 with mask=0 leaves itr=0. Writing mask=0x2 raises itr.
- Reset mid-operation: assert rst in the cycle a write to 0x0020 would fire. Expect out_regs=0, out_wstb=0, and all pending cleared.
